// File: rtl/wb_pkg.sv
// Shared write-back definitions: source-select encodings, datapath and address widths.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'b00,
        WB_SRC_MEM  = 2'b01,
        WB_SRC_PC4  = 2'b10,
        WB_SRC_RSVD = 2'b11
    } wb_src_e;

    // Write-back request as seen from the MEM/WB stage.
    typedef struct packed {
        logic              en;
        wb_src_e           src;
        logic [ADDR_W-1:0] addr;
    } wb_req_t;

    // A request changes state only for a live, non-zero, non-reserved destination.
    function automatic logic wb_req_commits(input wb_req_t req);
        return req.en && (req.addr != ADDR_W'(0)) && (req.src != WB_SRC_RSVD);
    endfunction

endpackage

// File: rtl/wb_src_mux.sv
// Write-back source selector; the sole driver of the write-back data seen by the
// register file and by the forwarding unit.
module wb_src_mux
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_mem,
    input  logic [DATA_W-1:0] i_pc4,
    output logic [DATA_W-1:0] o_data_c
);

    always_comb begin
        o_data_c = '0;
        case (wb_src_e'(i_sel))
            WB_SRC_ALU:  o_data_c = i_alu;
            WB_SRC_MEM:  o_data_c = i_mem;
            WB_SRC_PC4:  o_data_c = i_pc4;
            default:     o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Two-read, one-write register file with write-back source mux and commit counter.
// Define WB_REGFILE_BYPASS_EN to forward a committing write to same-cycle reads.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              RegWriteEN_In,
    input  logic [1:0]        Mem2RegSEL_In,
    input  logic [DATA_W-1:0] ALUResult_In,
    input  logic [DATA_W-1:0] MemResult_In,
    input  logic [DATA_W-1:0] PCPlus4_In,
    input  logic [4:0]        WriteBackRegAddr_In,
    input  logic [4:0]        ReadAddrA_In,
    input  logic [4:0]        ReadAddrB_In,
    output logic [DATA_W-1:0] ReadDataA_Out,
    output logic [DATA_W-1:0] ReadDataB_Out,
    output logic [DATA_W-1:0] WriteBackData_Out,
    output logic [31:0]       WriteCount_Out
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [31:0]       r_write_count;
    logic [DATA_W-1:0] w_wb_data;
    wb_req_t           w_req;
    logic              w_commit;

    wb_src_mux #(.DATA_W(DATA_W)) u_src_mux (
        .i_sel    (Mem2RegSEL_In),
        .i_alu    (ALUResult_In),
        .i_mem    (MemResult_In),
        .i_pc4    (PCPlus4_In),
        .o_data_c (w_wb_data)
    );

    assign WriteBackData_Out = w_wb_data;

    always_comb begin
        w_req.en   = RegWriteEN_In;
        w_req.src  = wb_src_e'(Mem2RegSEL_In);
        w_req.addr = WriteBackRegAddr_In;
    end

    // Reset outranks any concurrent write, so it also suppresses the bypass.
    assign w_commit = wb_req_commits(w_req) && !RESET
                   && (32'(WriteBackRegAddr_In) < NREGS);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
            r_write_count <= '0;
        end else if (w_commit) begin
            r_regs[WriteBackRegAddr_In] <= w_wb_data;
            r_write_count               <= r_write_count + 32'd1;
        end
    end

    assign WriteCount_Out = r_write_count;

    // Register 0 and unimplemented addresses always read as zero.
    function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if ((addr != 5'd0) && (32'(addr) < NREGS)) begin
            val = r_regs[addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (w_commit && (addr == WriteBackRegAddr_In)) begin
                val = w_wb_data;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        ReadDataA_Out = rd_port(ReadAddrA_In);
        ReadDataB_Out = rd_port(ReadAddrB_In);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven write/read vectors plus hand
// sequences for same-cycle bypass, counter wrap and reset-over-write.
module tb_wb_regfile;

    logic        CLOCK;
    logic        RESET;
    logic        RegWriteEN_In;
    logic [1:0]  Mem2RegSEL_In;
    logic [31:0] ALUResult_In;
    logic [31:0] MemResult_In;
    logic [31:0] PCPlus4_In;
    logic [4:0]  WriteBackRegAddr_In;
    logic [4:0]  ReadAddrA_In;
    logic [4:0]  ReadAddrB_In;
    logic [31:0] ReadDataA_Out;
    logic [31:0] ReadDataB_Out;
    logic [31:0] WriteBackData_Out;
    logic [31:0] WriteCount_Out;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_regfile dut (
        .CLOCK               (CLOCK),
        .RESET               (RESET),
        .RegWriteEN_In       (RegWriteEN_In),
        .Mem2RegSEL_In       (Mem2RegSEL_In),
        .ALUResult_In        (ALUResult_In),
        .MemResult_In        (MemResult_In),
        .PCPlus4_In          (PCPlus4_In),
        .WriteBackRegAddr_In (WriteBackRegAddr_In),
        .ReadAddrA_In        (ReadAddrA_In),
        .ReadAddrB_In        (ReadAddrB_In),
        .ReadDataA_Out       (ReadDataA_Out),
        .ReadDataB_Out       (ReadDataB_Out),
        .WriteBackData_Out   (WriteBackData_Out),
        .WriteCount_Out      (WriteCount_Out)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [31:0] alu, mem, pc4;
        logic [4:0]  wa, ra, rb;
        logic [31:0] exp_wb, exp_a, exp_b, exp_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string nm, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
            end
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] wa,
                         input logic [4:0] ra, input logic [4:0] rb);
        RegWriteEN_In       = en;
        Mem2RegSEL_In       = sel;
        ALUResult_In        = alu;
        MemResult_In        = mem;
        PCPlus4_In          = pc4;
        WriteBackRegAddr_In = wa;
        ReadAddrA_In        = ra;
        ReadAddrB_In        = rb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // en sel alu mem pc4 wa ra rb | exp_wb exp_a exp_b exp_cnt (after the edge)
        vecs[0] = '{1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'd1};
        vecs[1] = '{1'b1, 2'b00, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5,
                    32'h12345678, 32'h0, 32'hDEADBEEF, 32'd1};
        vecs[2] = '{1'b1, 2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 5'd7, 5'd7, 5'd7,
                    32'h0, 32'h0, 32'h0, 32'd1};
        vecs[3] = '{1'b1, 2'b10, 32'h0, 32'h0, 32'h00400008, 5'd31, 5'd31, 5'd5,
                    32'h00400008, 32'h00400008, 32'hDEADBEEF, 32'd2};
        vecs[4] = '{1'b1, 2'b01, 32'h0, 32'hCAFEF00D, 32'h0, 5'd12, 5'd12, 5'd31,
                    32'hCAFEF00D, 32'hCAFEF00D, 32'h00400008, 32'd3};
        vecs[5] = '{1'b0, 2'b01, 32'h0, 32'h0BADF00D, 32'h0, 5'd12, 5'd12, 5'd12,
                    32'h0BADF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'd3};
        vecs[6] = '{1'b1, 2'b00, 32'h00000001, 32'h0, 32'h0, 5'd5, 5'd5, 5'd12,
                    32'h00000001, 32'h00000001, 32'hCAFEF00D, 32'd4};

        RESET = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Every address reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            ReadAddrA_In = 5'(i);
            ReadAddrB_In = 5'(31 - i);
            #1;
            push($sformatf("reset_rda[%0d]", i), 32'h0);
            pop_cmp(ReadDataA_Out);
            push($sformatf("reset_rdb[%0d]", 31 - i), 32'h0);
            pop_cmp(ReadDataB_Out);
        end
        push("reset_count", 32'h0);
        pop_cmp(WriteCount_Out);

        for (int v = 0; v < 7; v++) begin
            @(negedge CLOCK);
            drive(vecs[v].en, vecs[v].sel, vecs[v].alu, vecs[v].mem, vecs[v].pc4,
                  vecs[v].wa, vecs[v].ra, vecs[v].rb);
            #1;
            push($sformatf("vec%0d_wbdata", v), vecs[v].exp_wb);
            pop_cmp(WriteBackData_Out);
            push($sformatf("vec%0d_rda", v), vecs[v].exp_a);
            push($sformatf("vec%0d_rdb", v), vecs[v].exp_b);
            push($sformatf("vec%0d_count", v), vecs[v].exp_cnt);
            @(posedge CLOCK);
            #1;
            pop_cmp(ReadDataA_Out);
            pop_cmp(ReadDataB_Out);
            pop_cmp(WriteCount_Out);
        end

        // Same-cycle read of a register being written: bypassed or old value.
        @(negedge CLOCK);
        drive(1'b1, 2'b00, 32'h99990000, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0);
        @(negedge CLOCK);
        drive(1'b1, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        #1;
        push("bypass_same_cycle_b", BYP ? 32'hA5A5A5A5 : 32'h99990000);
        pop_cmp(ReadDataB_Out);
        push("bypass_same_cycle_a", BYP ? 32'hA5A5A5A5 : 32'h99990000);
        pop_cmp(ReadDataA_Out);
        @(posedge CLOCK);
        #1;
        push("bypass_next_cycle_b", 32'hA5A5A5A5);
        pop_cmp(ReadDataB_Out);
        push("bypass_count", 32'd6);
        pop_cmp(WriteCount_Out);

        // Reserved select must not bypass nor write, even with a matching address.
        @(negedge CLOCK);
        drive(1'b1, 2'b11, 32'h5A5A5A5A, 32'h0, 32'h0, 5'd9, 5'd0, 5'd9);
        #1;
        push("rsvd_same_cycle_b", 32'hA5A5A5A5);
        pop_cmp(ReadDataB_Out);
        @(posedge CLOCK);
        #1;
        push("rsvd_next_cycle_b", 32'hA5A5A5A5);
        pop_cmp(ReadDataB_Out);
        push("rsvd_count", 32'd6);
        pop_cmp(WriteCount_Out);

        // Counter wrap: preset to all-ones, then commit one write.
        @(negedge CLOCK);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
        force dut.r_write_count = 32'hFFFFFFFF;
        #1;
        release dut.r_write_count;
        #1;
        push("wrap_preset_count", 32'hFFFFFFFF);
        pop_cmp(WriteCount_Out);
        drive(1'b1, 2'b00, 32'h00000005, 32'h0, 32'h0, 5'd2, 5'd2, 5'd0);
        @(posedge CLOCK);
        #1;
        push("wrap_count", 32'h0);
        pop_cmp(WriteCount_Out);
        push("wrap_reg2", 32'h00000005);
        pop_cmp(ReadDataA_Out);

        // Reset wins over a concurrent write.
        @(negedge CLOCK);
        RESET = 1'b1;
        drive(1'b1, 2'b00, 32'h00000077, 32'h0, 32'h0, 5'd3, 5'd3, 5'd2);
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd2);
        #1;
        push("rst_write_reg3", 32'h0);
        pop_cmp(ReadDataA_Out);
        push("rst_reg2", 32'h0);
        pop_cmp(ReadDataB_Out);
        push("rst_count", 32'h0);
        pop_cmp(WriteCount_Out);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32: datapath and register width.
REQ-002 Parameter NREGS, default 32: register count; address width is 5 bits.
REQ-003 Port CLOCK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 Port RegWriteEN_In, input, 1 bit: write-back enable from the MEM/WB stage.
REQ-006 Port Mem2RegSEL_In, input, 2 bits: write-back source select.
REQ-007 Port ALUResult_In, input, 32 bits: write-back source 00.
REQ-008 Port MemResult_In, input, 32 bits: write-back source 01.
REQ-009 Port PCPlus4_In, input, 32 bits: write-back source 10 (link).
REQ-010 Port WriteBackRegAddr_In, input, 5 bits: destination register.
REQ-011 Port ReadAddrA_In / ReadAddrB_In, input, 5 bits each: decode-stage source addresses.
REQ-012 Port ReadDataA_Out / ReadDataB_Out, output, 32 bits each: read data.
REQ-013 Port WriteBackData_Out, output, 32 bits: selected write-back value, combinational, for the forwarding unit.
REQ-014 Port WriteCount_Out, output, 32 bits: count of committed register writes.

Function
REQ-015 WriteBackData_Out SHALL select by Mem2RegSEL_In: 00 gives ALUResult_In, 01 gives MemResult_In, 10 gives PCPlus4_In, 11 gives 0.
REQ-016 A write SHALL commit on a rising CLOCK edge only when all of these hold: RegWriteEN_In=1, WriteBackRegAddr_In≠0, Mem2RegSEL_In≠11, and RESET=0.
REQ-017 A committed write SHALL store WriteBackData_Out into the register at WriteBackRegAddr_In; the new value is visible starting the next cycle.
REQ-018 Register 0 SHALL always read as 0; writes to it SHALL be dropped and SHALL NOT increment WriteCount_Out.
REQ-019 Reads SHALL be combinational, with zero latency from ReadAddrA_In / ReadAddrB_In to the outputs.
REQ-020 Both read ports SHALL operate independently and SHALL allow the same address on both.
REQ-021 WriteCount_Out SHALL increment by 1 on each committed write and SHALL wrap from 0xFFFFFFFF to 0.
REQ-022 An enable with select 11 SHALL have no state effect; this is the reserved-encoding guard.

Reset
REQ-023 While RESET=1 at a rising edge, all registers and WriteCount_Out SHALL become 0, and any concurrent write SHALL be discarded.
REQ-024 After reset, ReadDataA_Out and ReadDataB_Out SHALL read 0 for every address until a write commits.

Configuration
REQ-025 Macro WB_REGFILE_BYPASS_EN SHALL control same-cycle read bypass.
REQ-026 With WB_REGFILE_BYPASS_EN defined, when a write is committing this cycle and a read address equals WriteBackRegAddr_In (nonzero), that read port SHALL return WriteBackData_Out in the same cycle.
REQ-027 Without WB_REGFILE_BYPASS_EN, the read port SHALL return the old stored value in that cycle; the decode stage then inserts a stall or forward.

Structure
REQ-028 Shared package wb_pkg SHALL hold: the Mem2RegSEL encodings (WB_SRC_ALU=00, WB_SRC_MEM=01, WB_SRC_PC4=10, WB_SRC_RSVD=11), DATA_W, and the address width.
REQ-029 Sub-module wb_src_mux SHALL implement REQ-015 and SHALL be the only source of WriteBackData_Out.

Verification
REQ-030 Reset, then read all 32 addresses -> all 0; WriteCount_Out=0.
REQ-031 Write 0xDEADBEEF to reg 5 with select 00 -> next cycle ReadDataA_Out=0xDEADBEEF at addr 5; WriteCount_Out=1.
REQ-032 Write 0x12345678 to reg 0 with enable=1 -> reg 0 still reads 0; WriteCount_Out unchanged.
REQ-033 Write with select 11 to reg 7 -> reg 7 unchanged and count unchanged; select 10 with PCPlus4_In=0x00400008 to reg 31 -> reg 31 reads 0x00400008.
REQ-034 Write 0xA5A5A5A5 to reg 9 while ReadAddrB_In=9 -> same-cycle ReadDataB_Out is 0xA5A5A5A5 with the bypass macro and the prior value without it.
REQ-035 Preload count to 0xFFFFFFFF via repeated writes (or force it), commit one write -> count=0; assert RESET together with a write to reg 3 -> reg 3 reads 0 and count=0.
